// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, owner tags and
// the byte-mask width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } arb_state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  // MASK_WIDTH = DATA_WIDTH/8; a function because the data width is a module parameter.
  function automatic int unsigned mask_width(int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin grant between fetch and load/store requesters.
// Purely combinational; the last-grant register lives in the parent.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   ifu_valid_i,
  input  logic   lsu_valid_i,
  input  owner_e last_grant_i,
  output logic   ifu_gnt_o,
  output logic   lsu_gnt_o
);

  // On a tie, the side that did not win last time goes first.
  always_comb begin
    ifu_gnt_o = ifu_valid_i && (!lsu_valid_i || (last_grant_i == OWN_LSU));
    lsu_gnt_o = lsu_valid_i && (!ifu_valid_i || (last_grant_i == OWN_IFU));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store paths, with
// round-robin on ties and a single outstanding transaction.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned INST_WIDTH = `INST_WIDTH
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst_n,
  // Instruction fetch path
  input  logic                    i_ifu_req_valid,
  output logic                    o_ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_ifu_req_addr,
  output logic                    o_ifu_rsp_valid,
  output logic [INST_WIDTH-1:0]   o_ifu_rsp_data,
  // Load/store path
  input  logic                    i_lsu_req_valid,
  output logic                    o_lsu_req_ready,
  input  logic                    i_lsu_req_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_lsu_req_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_lsu_req_wr_mask,
  output logic                    o_lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_lsu_rsp_data,
  // Memory side
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic                    o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_mem_wr_mask,
  input  logic                    i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rsp_data
);

  localparam int unsigned MASK_WIDTH = mask_width(DATA_WIDTH);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_grant_q, last_grant_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [MASK_WIDTH-1:0] wr_mask_q, wr_mask_d;

  logic ifu_gnt, lsu_gnt;
  logic ifu_ready, lsu_ready;
  logic mem_valid;
  logic ifu_rsp_valid, lsu_rsp_valid;

  mem_arb_rr u_rr (
    .ifu_valid_i  (i_ifu_req_valid),
    .lsu_valid_i  (i_lsu_req_valid),
    .last_grant_i (last_grant_q),
    .ifu_gnt_o    (ifu_gnt),
    .lsu_gnt_o    (lsu_gnt)
  );

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      wr_mask_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      wr_mask_q    <= wr_mask_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    wr_en_d       = wr_en_q;
    addr_d        = addr_q;
    wr_data_d     = wr_data_q;
    wr_mask_d     = wr_mask_q;
    ifu_ready     = 1'b0;
    lsu_ready     = 1'b0;
    mem_valid     = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Reset forces IDLE asynchronously; keep ready low while it is held so all
        // outputs read zero during reset.
        ifu_ready = ifu_gnt && i_sys_rst_n;
        lsu_ready = lsu_gnt && i_sys_rst_n;
        if (ifu_ready) begin
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          wr_en_d      = 1'b0;
          addr_d       = i_ifu_req_addr;
          wr_data_d    = '0;
          wr_mask_d    = '0;
          state_d      = REQ;
        end else if (lsu_ready) begin
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          wr_en_d      = i_lsu_req_wr_en;
          addr_d       = i_lsu_req_addr;
          wr_data_d    = i_lsu_req_wr_data;
          wr_mask_d    = i_lsu_req_wr_mask;
          state_d      = REQ;
        end
      end
      REQ: begin
        mem_valid = 1'b1;
        if (i_mem_ready) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (i_mem_rsp_valid) begin
          if (owner_q == OWN_IFU) begin
            ifu_rsp_valid = 1'b1;
          end else begin
            lsu_rsp_valid = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ifu_req_ready = ifu_ready;
  assign o_lsu_req_ready = lsu_ready;

  // Memory fields read zero whenever no request is being presented.
  assign o_mem_valid   = mem_valid;
  assign o_mem_wr_en   = mem_valid && wr_en_q;
  assign o_mem_addr    = mem_valid ? addr_q : '0;
  assign o_mem_wr_data = mem_valid ? wr_data_q : '0;
  assign o_mem_wr_mask = mem_valid ? wr_mask_q : '0;

  assign o_ifu_rsp_valid = ifu_rsp_valid;
  assign o_ifu_rsp_data  = ifu_rsp_valid ? i_mem_rsp_data[INST_WIDTH-1:0] : '0;
  assign o_lsu_rsp_valid = lsu_rsp_valid;
  // A write acknowledge carries no data.
  assign o_lsu_rsp_data  = (lsu_rsp_valid && !wr_en_q) ? i_mem_rsp_data : '0;

`ifndef SYNTHESIS
  a_ifu_ready_needs_valid : assert property (@(posedge i_sys_clk)
    o_ifu_req_ready |-> i_ifu_req_valid);
  a_lsu_ready_needs_valid : assert property (@(posedge i_sys_clk)
    o_lsu_req_ready |-> i_lsu_req_valid);
  a_single_rsp : assert property (@(posedge i_sys_clk)
    !(o_ifu_rsp_valid && o_lsu_rsp_valid));
  a_mem_req_stable : assert property (@(posedge i_sys_clk) disable iff (!i_sys_rst_n)
    (o_mem_valid && !i_mem_ready) |=> (o_mem_valid &&
      $stable({o_mem_wr_en, o_mem_addr, o_mem_wr_data, o_mem_wr_mask})));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 16;
  localparam int unsigned MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_valid, ifu_ready, ifu_rsp_valid;
  logic [AW-1:0] ifu_addr;
  logic [IW-1:0] ifu_rsp_data;
  logic          lsu_valid, lsu_ready, lsu_wr, lsu_rsp_valid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rsp_data;
  logic [MW-1:0] lsu_mask;
  logic          mem_valid, mem_ready, mem_wr_en, mem_rsp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rsp_data;
  logic [MW-1:0] mem_wr_mask;

  logic [121:0] all_outs;
  int n_checks = 0;
  int n_fail   = 0;
  int rsp_pulses = 0;
  bit last_lsu;  // model: LSU won the most recent arbitration

  always #5 clk = ~clk;

  assign all_outs = {ifu_ready, ifu_rsp_valid, ifu_rsp_data, lsu_ready, lsu_rsp_valid,
                     lsu_rsp_data, mem_valid, mem_wr_en, mem_addr, mem_wr_data, mem_wr_mask};

  always @(negedge clk) rsp_pulses += int'(ifu_rsp_valid) + int'(lsu_rsp_valid);

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INST_WIDTH (IW)
  ) dut (
    .i_sys_clk         (clk),
    .i_sys_rst_n       (rst_n),
    .i_ifu_req_valid   (ifu_valid),
    .o_ifu_req_ready   (ifu_ready),
    .i_ifu_req_addr    (ifu_addr),
    .o_ifu_rsp_valid   (ifu_rsp_valid),
    .o_ifu_rsp_data    (ifu_rsp_data),
    .i_lsu_req_valid   (lsu_valid),
    .o_lsu_req_ready   (lsu_ready),
    .i_lsu_req_wr_en   (lsu_wr),
    .i_lsu_req_addr    (lsu_addr),
    .i_lsu_req_wr_data (lsu_wdata),
    .i_lsu_req_wr_mask (lsu_mask),
    .o_lsu_rsp_valid   (lsu_rsp_valid),
    .o_lsu_rsp_data    (lsu_rsp_data),
    .o_mem_valid       (mem_valid),
    .i_mem_ready       (mem_ready),
    .o_mem_wr_en       (mem_wr_en),
    .o_mem_addr        (mem_addr),
    .o_mem_wr_data     (mem_wr_data),
    .o_mem_wr_mask     (mem_wr_mask),
    .i_mem_rsp_valid   (mem_rsp_valid),
    .i_mem_rsp_data    (mem_rsp_data)
  );

  task automatic clear_inputs();
    ifu_valid = 0; ifu_addr = '0;
    lsu_valid = 0; lsu_wr = 0; lsu_addr = '0; lsu_wdata = '0; lsu_mask = '0;
    mem_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge, out of reset.
  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    last_lsu = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    ifu_valid = 1; lsu_valid = 1; mem_rsp_valid = 1; mem_ready = 1;
    @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_held_outs: got %h expected 0", all_outs);
    end
    n_checks++;
    if ({ifu_ready, lsu_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 00", {ifu_ready, lsu_ready});
    end
    @(posedge clk);
    #1 rst_n = 1;
    last_lsu = 1;
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_idle_outs: got %h expected 0", all_outs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ifu_read();
    logic [AW-1:0] a;
    a = 32'h8000_0000;
    ifu_valid = 1; ifu_addr = a; mem_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({ifu_ready, lsu_ready, mem_valid} !== 3'b100) begin
      n_fail++; $display("FAIL ifu_accept: got %b expected 100", {ifu_ready, lsu_ready, mem_valid});
    end
    @(posedge clk); #1;
    ifu_valid = 0; ifu_addr = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if ({mem_valid, mem_wr_en, mem_addr, mem_wr_data, mem_wr_mask} !== {2'b10, a, 32'h0, 4'h0})
    begin
      n_fail++; $display("FAIL ifu_mem_req: got v=%b we=%b a=%h d=%h m=%h", mem_valid,
                         mem_wr_en, mem_addr, mem_wr_data, mem_wr_mask);
    end
    @(posedge clk); #1;
    mem_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0013;
    @(negedge clk);
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid, lsu_rsp_data, lsu_ready, mem_valid} !==
        {1'b1, 16'h0013, 1'b0, 32'h0, 2'b00}) begin
      n_fail++; $display("FAIL ifu_rsp: got iv=%b id=%h lv=%b ld=%h", ifu_rsp_valid,
                         ifu_rsp_data, lsu_rsp_valid, lsu_rsp_data);
    end
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_data, mem_valid} !== '0) begin
      n_fail++; $display("FAIL ifu_rsp_done: got iv=%b id=%h mv=%b", ifu_rsp_valid,
                         ifu_rsp_data, mem_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alternation();
    logic [3:0] seq;
    seq = 4'b1010;  // bit k set: LSU wins transaction k
    do_reset();
    ifu_valid = 1; ifu_addr = 32'h1000;
    lsu_valid = 1; lsu_addr = 32'h2000; lsu_wr = 0; lsu_wdata = 32'h77; lsu_mask = 4'hf;
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1;
      @(negedge clk);
      n_checks++;
      if ({ifu_ready, lsu_ready} !== (seq[k] ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL alt_grant%0d: got ifu/lsu ready %b expected %b", k,
                           {ifu_ready, lsu_ready}, (seq[k] ? 2'b01 : 2'b10));
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (mem_addr !== (seq[k] ? 32'h2000 : 32'h1000)) begin
        n_fail++; $display("FAIL alt_addr%0d: got %h expected %h", k, mem_addr,
                           (seq[k] ? 32'h2000 : 32'h1000));
      end
      @(posedge clk); #1;
      mem_ready = 0; mem_rsp_valid = 1; mem_rsp_data = $urandom;
      @(negedge clk);
      n_checks++;
      if ({ifu_rsp_valid, lsu_rsp_valid} !== (seq[k] ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL alt_rsp%0d: got ifu/lsu rsp %b", k, {ifu_rsp_valid, lsu_rsp_valid});
      end
      @(posedge clk); #1;
      mem_rsp_valid = 0;
    end
    clear_inputs();
    last_lsu = 1;
  endtask

  task automatic test_lsu_write();
    lsu_valid = 1; lsu_wr = 1; lsu_addr = 32'h100; lsu_wdata = 32'hDEAD_BEEF; lsu_mask = 4'h3;
    mem_ready = 0;
    @(negedge clk);
    n_checks++;
    if ({ifu_ready, lsu_ready} !== 2'b01) begin
      n_fail++; $display("FAIL wr_accept: got %b expected 01", {ifu_ready, lsu_ready});
    end
    @(posedge clk); #1;
    lsu_valid = 0; lsu_wr = 0; lsu_addr = 32'hFFF; lsu_wdata = '0; lsu_mask = '0;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      @(negedge clk);
      n_checks++;
      if ({mem_valid, mem_wr_en, mem_addr, mem_wr_data, mem_wr_mask} !==
          {2'b11, 32'h100, 32'hDEAD_BEEF, 4'h3}) begin
        n_fail++; $display("FAIL wr_hold%0d: got v=%b we=%b a=%h d=%h m=%h", c, mem_valid,
                           mem_wr_en, mem_addr, mem_wr_data, mem_wr_mask);
      end
      @(posedge clk); #1;
    end
    mem_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D;
    @(negedge clk);
    n_checks++;
    if ({lsu_rsp_valid, lsu_rsp_data, ifu_rsp_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL wr_ack: got lv=%b ld=%h iv=%b expected 1/0/0", lsu_rsp_valid,
                         lsu_rsp_data, ifu_rsp_valid);
    end
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    last_lsu = 1;
  endtask

  task automatic test_lsu_read_delayed();
    int base;
    @(negedge clk);
    base = rsp_pulses;
    @(posedge clk); #1;
    mem_rsp_valid = 1; mem_rsp_data = 32'h5555_5555;  // spurious, in IDLE
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    lsu_valid = 1; lsu_wr = 0; lsu_addr = 32'h200; lsu_wdata = 32'h9; lsu_mask = 4'h1;
    @(negedge clk);
    n_checks++;
    if (lsu_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd_accept: got %b expected 1", lsu_ready);
    end
    @(posedge clk); #1;
    lsu_valid = 0;
    mem_rsp_valid = 1;  // spurious, in REQ
    @(negedge clk);
    n_checks++;
    if ({mem_valid, ifu_rsp_valid, lsu_rsp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL rd_req_spurious: got %b expected 100",
                         {mem_valid, ifu_rsp_valid, lsu_rsp_valid});
    end
    @(posedge clk); #1;
    mem_rsp_valid = 0; mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if ({lsu_rsp_valid, lsu_rsp_data, ifu_rsp_valid} !== {1'b1, 32'h1234_5678, 1'b0}) begin
      n_fail++; $display("FAIL rd_rsp: got lv=%b ld=%h iv=%b", lsu_rsp_valid, lsu_rsp_data,
                         ifu_rsp_valid);
    end
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    @(posedge clk); #1;
    n_checks++;
    if (rsp_pulses - base !== 1) begin
      n_fail++; $display("FAIL rd_pulse_count: got %0d expected 1", rsp_pulses - base);
    end
    last_lsu = 1;
  endtask

  task automatic test_reset_midflight();
    int base;
    // Reset while in REQ
    ifu_valid = 1; ifu_addr = 32'h300; mem_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (mem_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_req_setup: mem_valid got %b expected 1", mem_valid);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL rst_in_req: got %h expected 0", all_outs);
    end
    ifu_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    last_lsu = 1;
    base = rsp_pulses;
    mem_rsp_valid = 1; mem_rsp_data = 32'hABCD;
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    // Reset while in RSP
    lsu_valid = 1; lsu_wr = 0; lsu_addr = 32'h400; mem_ready = 1;
    @(posedge clk); #1;
    lsu_valid = 0;
    @(posedge clk); #1;
    mem_ready = 0;
    @(negedge clk);
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_rsp_setup: mem_valid got %b expected 0", mem_valid);
    end
    #2 rst_n = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'hBEEF;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL rst_in_rsp: got %h expected 0", all_outs);
    end
    @(posedge clk); #1;
    rst_n = 1;
    last_lsu = 1;
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    n_checks++;
    if (rsp_pulses !== base) begin
      n_fail++; $display("FAIL rst_late_rsp: got %0d pulses expected 0", rsp_pulses - base);
    end
    ifu_valid = 1; lsu_valid = 1;
    @(negedge clk);
    n_checks++;
    if ({ifu_ready, lsu_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rst_first_tie: got %b expected 10", {ifu_ready, lsu_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit            ip, lp, win_lsu, lw;
    logic [AW-1:0] ia, la;
    logic [DW-1:0] ld, rd;
    logic [MW-1:0] lm;
    logic [1+AW+DW+MW:0]   exp_mem;
    logic [1+IW+1+DW-1:0]  exp_rsp;
    int d, r;
    do_reset();
    ip = 0; lp = 0;
    for (int t = 0; t < 60; t++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ia = $urandom;
      end
      if (!lp && $urandom_range(0, 1) == 1) begin
        lp = 1; la = $urandom; ld = $urandom; lm = MW'($urandom_range(0, 15));
        lw = 1'($urandom_range(0, 1));
      end
      ifu_valid = ip; ifu_addr = ia;
      lsu_valid = lp; lsu_addr = la; lsu_wdata = ld; lsu_mask = lm; lsu_wr = lw;
      mem_rsp_valid = 1'($urandom_range(0, 1));
      win_lsu = (ip && lp) ? !last_lsu : lp;
      d = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      mem_ready = (d == 0);
      @(negedge clk);
      n_checks++;
      if ({ifu_ready, lsu_ready, ifu_rsp_valid, lsu_rsp_valid} !==
          {ip && !win_lsu, lp && win_lsu, 2'b00}) begin
        n_fail++; $display("FAIL rnd_grant%0d: got %b expected %b", t,
                           {ifu_ready, lsu_ready, ifu_rsp_valid, lsu_rsp_valid},
                           {ip && !win_lsu, lp && win_lsu, 2'b00});
      end
      @(posedge clk); #1;
      mem_rsp_valid = 0;
      if (!ip && !lp) continue;
      last_lsu = win_lsu;
      if (win_lsu) begin
        lp = 0; lsu_valid = 0; lsu_addr = $urandom; lsu_wdata = $urandom;
        exp_mem = {1'b1, lw, la, ld, lm};
      end else begin
        ip = 0; ifu_valid = 0; ifu_addr = $urandom;
        exp_mem = {1'b1, 1'b0, ia, {DW{1'b0}}, {MW{1'b0}}};
      end
      for (int c = 0; c <= d; c++) begin
        mem_ready = (c == d);
        @(negedge clk);
        n_checks++;
        if ({mem_valid, mem_wr_en, mem_addr, mem_wr_data, mem_wr_mask, ifu_ready, lsu_ready} !==
            {exp_mem, 2'b00}) begin
          n_fail++; $display("FAIL rnd_mem%0d: got v=%b we=%b a=%h d=%h m=%h rdy=%b", t,
                             mem_valid, mem_wr_en, mem_addr, mem_wr_data, mem_wr_mask,
                             {ifu_ready, lsu_ready});
        end
        @(posedge clk); #1;
      end
      mem_ready = 0;
      for (int c = 0; c <= r; c++) begin
        rd = $urandom;
        mem_rsp_valid = (c == r); mem_rsp_data = rd;
        if (c < r) exp_rsp = '0;
        else if (win_lsu) exp_rsp = {1'b0, {IW{1'b0}}, 1'b1, (lw ? {DW{1'b0}} : rd)};
        else exp_rsp = {1'b1, rd[IW-1:0], 1'b0, {DW{1'b0}}};
        @(negedge clk);
        n_checks++;
        if ({ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid, lsu_rsp_data} !== exp_rsp) begin
          n_fail++; $display("FAIL rnd_rsp%0d: got iv=%b id=%h lv=%b ld=%h expected %h", t,
                             ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid, lsu_rsp_data, exp_rsp);
        end
        @(posedge clk); #1;
      end
      mem_rsp_valid = 0;
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_ifu_read();
    test_alternation();
    test_lsu_write();
    test_lsu_read_delayed();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch and load/store request paths of the core.
- Sits directly downstream of the core's instruction and data memory ports, and upstream of a single-port memory/bus slave.
- Arbitrates between the two paths with round-robin on ties and keeps one transaction outstanding.
- Uses valid/ready handshakes on both sides and returns each response to its originator.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH: request address width.
- DATA_WIDTH, `DATA_WIDTH: data width. Mask width is DATA_WIDTH/8.
- INST_WIDTH, `INST_WIDTH: instruction width. Must be ≤ DATA_WIDTH.

Ports:
- i_sys_clk  in  1  system clock (sole clock).
- i_sys_rst_n  in  1  reset, asynchronous, active-low.
- i_ifu_req_valid  in  1  fetch request valid.
- o_ifu_req_ready  out  1  fetch request accepted this cycle.
- i_ifu_req_addr  in  ADDR_WIDTH  fetch address.
- o_ifu_rsp_valid  out  1  fetch data valid (single-cycle pulse).
- o_ifu_rsp_data  out  INST_WIDTH  fetched instruction, taken from the low bits of memory data.
- i_lsu_req_valid  in  1  data request valid.
- o_lsu_req_ready  out  1  data request accepted.
- i_lsu_req_wr_en  in  1  1 = write, 0 = read.
- i_lsu_req_addr  in  ADDR_WIDTH  data address.
- i_lsu_req_wr_data  in  DATA_WIDTH  write data.
- i_lsu_req_wr_mask  in  DATA_WIDTH/8  byte write mask.
- o_lsu_rsp_valid  out  1  read data valid or write acknowledge (pulse).
- o_lsu_rsp_data  out  DATA_WIDTH  read data. Zero for a write acknowledge.
- o_mem_valid  out  1  memory request valid.
- i_mem_ready  in  1  memory accepts the request.
- o_mem_wr_en  out  1  memory write.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_wr_data  out  DATA_WIDTH  memory write data.
- o_mem_wr_mask  out  DATA_WIDTH/8  memory byte mask.
- i_mem_rsp_valid  in  1  memory response/ack valid.
- i_mem_rsp_data  in  DATA_WIDTH  memory read data.

Behaviour:
- FSM states: IDLE, REQ, RSP. Reset state is IDLE.
- Registers: r_owner (IFU/LSU), r_last_grant, and the latched request fields (wr_en, addr, wr_data, wr_mask).
- Reset values: r_last_grant = LSU, so the first tie goes to IFU. All latched fields are 0. All outputs are 0.
- IDLE, grant selection:
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to r_last_grant is granted.
  - o_x_req_ready = (state == IDLE) && grant_x. It is combinational and never asserted for a non-valid requester.
- IDLE, on handshake: latch the request fields, set r_owner and r_last_grant to the winner, go to REQ.
- IFU requests latch wr_en=0, wr_data=0 and mask=0.
- REQ: drive o_mem_valid=1 with the latched fields, held stable until i_mem_ready. On o_mem_valid && i_mem_ready, go to RSP.
- RSP:
  - o_mem_valid=0.
  - On i_mem_rsp_valid, pulse the owner's rsp_valid for that same cycle, with data routed combinationally from i_mem_rsp_data, then go to IDLE.
  - A write ack pulses o_lsu_rsp_valid with o_lsu_rsp_data=0.
- i_mem_rsp_valid is ignored in IDLE and REQ.
- Response channels have no backpressure; the consumer must take the pulse.
- rsp_data outputs are 0 when the corresponding rsp_valid is 0.
- Minimum latency: accept at cycle T, memory handshake at T+1, response at T+2, next accept at T+3.
- At most one transaction is outstanding. The non-granted requester simply sees ready=0 and must hold its request.
- Reset mid-transaction: asynchronous return to IDLE. The in-flight transaction is dropped with no response. A late i_mem_rsp_valid after reset is ignored.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, REQ, RSP};
  - owner enum {OWN_IFU, OWN_LSU};
  - MASK_WIDTH = DATA_WIDTH/8.
- One sub-module, mem_arb_rr: a two-input round-robin grant computed from both valids and r_last_grant. Purely combinational; the r_last_grant register stays in the parent.

Test Plan:
- IFU read addr 0x8000_0000 alone; memory ready at once; rsp 0x0000_0013 one cycle later → ifu ready at T, o_mem_valid at T+1 with wr_en=0, o_ifu_rsp_valid/data=0x13 at T+2, lsu outputs quiet.
- Both valid at the first arbitration after reset → IFU granted first. Next IDLE with both still valid → LSU granted. Then IFU again (alternation over 4 transactions).
- LSU write addr 0x100, data 0xDEADBEEF, mask 0x3; i_mem_ready held low 3 cycles → o_mem_* stable for 4 cycles. Ack gives o_lsu_rsp_valid=1 with data=0.
- LSU read with i_mem_rsp_valid delayed 5 cycles and a spurious i_mem_rsp_valid in IDLE → only one rsp pulse, in RSP, with data 0x12345678. The spurious pulse is ignored.
- Assert i_sys_rst_n=0 during REQ and during RSP → all outputs 0 immediately. Post-reset a late mem rsp gives no response, and the first tie is granted to IFU.
